// File: rtl/main_fsm_gen.sv
// Multicycle ARM control FSM with memory wait states, multi-beat wide write-back and a sticky fault state.
// The FPU start/done path is built only when MAIN_FSM_FPU_EN is defined.
module main_fsm_gen #(
    parameter int WB_WORDS     = 2,
    parameter int MEM_WAIT_MAX = 15,
    parameter int FPU_TIMEOUT  = 31,
    localparam int WSEL_W      = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              wide_flag,
    input  logic              mem_ready,
    input  logic              fpu_done,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic              NextPC,
    output logic              RegW,
    output logic              MemW,
    output logic              Branch,
    output logic              ALUOp,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [WSEL_W-1:0] WideSel,
    output logic              FpuStart,
    output logic              FpuW,
    output logic              Fault,
    output logic [3:0]        state_o
);

    localparam int LIM_MAX = (MEM_WAIT_MAX > FPU_TIMEOUT) ? MEM_WAIT_MAX : FPU_TIMEOUT;
    localparam int CNT_W   = $clog2(LIM_MAX + 1);
    localparam logic [CNT_W-1:0]  MEM_LIM   = CNT_W'(MEM_WAIT_MAX);
    localparam logic [WSEL_W-1:0] BEAT_LAST = WSEL_W'(WB_WORDS - 1);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_WIDEWB   = 4'd13;
    localparam logic [3:0] S_FAULT    = 4'd15;
`ifdef MAIN_FSM_FPU_EN
    localparam logic [3:0] S_EXECUTEF = 4'd11;
    localparam logic [3:0] S_FPUWB    = 4'd12;
    localparam logic [CNT_W-1:0] FPU_LIM = CNT_W'(FPU_TIMEOUT);
`endif

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WSEL_W-1:0] beat_q, beat_d;
    logic              waiting_s;
    logic              unused_s;

`ifdef MAIN_FSM_FPU_EN
    assign unused_s = ^Funct[4:1];
`else
    assign unused_s = ^{Funct[4:1], fpu_done};
`endif

    // Next-state logic; waiting_s flags a cycle spent waiting on mem_ready/fpu_done.
    always_comb begin
        state_d   = state_q;
        waiting_s = 1'b0;
        case (state_q)
            S_FETCH, S_MEMRD: begin
                if (mem_ready) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_MEMWB;
                end else begin
                    waiting_s = 1'b1;
                    state_d   = (wait_cnt_q == MEM_LIM) ? S_FAULT : state_q;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    waiting_s = 1'b1;
                    state_d   = (wait_cnt_q == MEM_LIM) ? S_FAULT : S_MEMWR;
                end
            end
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
`ifdef MAIN_FSM_FPU_EN
                    2'b11:   state_d = S_EXECUTEF;
`else
                    2'b11:   state_d = S_FAULT;
`endif
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXECUTER, S_EXECUTEI: state_d = wide_flag ? S_WIDEWB : S_ALUWB;
            S_ALUWB, S_MEMWB, S_BRANCH: state_d = S_FETCH;
            S_WIDEWB: state_d = (beat_q == BEAT_LAST) ? S_FETCH : S_WIDEWB;
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
`ifdef MAIN_FSM_FPU_EN
            S_EXECUTEF: begin
                if (fpu_done) begin
                    state_d = S_FPUWB;
                end else begin
                    waiting_s = 1'b1;
                    state_d   = (wait_cnt_q == FPU_LIM) ? S_FAULT : S_EXECUTEF;
                end
            end
            S_FPUWB: state_d = S_FETCH;
`endif
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Wait counter restarts on every state change; beat counter only advances while staying in WIDEWB.
    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (waiting_s) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        if ((state_q == S_WIDEWB) && (state_d == S_WIDEWB)) begin
            beat_d = beat_q + 1'b1;
        end else begin
            beat_d = {WSEL_W{1'b0}};
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= {CNT_W{1'b0}};
            beat_q     <= {WSEL_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        WideSel   = {WSEL_W{1'b0}};
        FpuStart  = 1'b0;
        FpuW      = 1'b0;
        Fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  RegW = 1'b1;
            S_WIDEWB: begin
                RegW    = 1'b1;
                WideSel = beat_q;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
            end
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
`ifdef MAIN_FSM_FPU_EN
            // The counter is still zero only on the first EXECUTEF cycle.
            S_EXECUTEF: FpuStart = (wait_cnt_q == {CNT_W{1'b0}});
            S_FPUWB:    FpuW = 1'b1;
`endif
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_main_fsm_gen.sv
// Scoreboard bench for main_fsm_gen (WB_WORDS=4): the driver queues the expected state and
// control vector for each cycle, a negedge monitor pops and compares.
module tb_main_fsm_gen;

    localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3,  MB = 4'd4;
    localparam logic [3:0] MW = 4'd5,  ER = 4'd6,  EI = 4'd7,  AW = 4'd8,  BR = 4'd9;
    localparam logic [3:0] EF = 4'd11, FW = 4'd12, WW = 4'd13, FL = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       wide_flag, mem_ready, fpu_done;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, WideSel;
    logic       FpuStart, FpuW, Fault;
    logic [3:0] state_o;
    logic [17:0] dut_ctl;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   rec_n      = 0;

    main_fsm_gen #(.WB_WORDS(4), .MEM_WAIT_MAX(15), .FPU_TIMEOUT(31)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .wide_flag(wide_flag),
        .mem_ready(mem_ready), .fpu_done(fpu_done), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .WideSel(WideSel),
        .FpuStart(FpuStart), .FpuW(FpuW), .Fault(Fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
                      ALUSrcA, ALUSrcB, ResultSrc, WideSel, FpuStart, FpuW, Fault};

    // Per-state output table as listed for each state; everything else is 0.
    function automatic logic [17:0] ctl_of(input logic [3:0] st, input logic mr,
                                           input logic [1:0] ws, input logic fs);
        logic irw, adr, npc, rw, mw, br, aop, fst, fw, flt;
        logic [1:0] sa, sb, rs, wsel;
        {irw, adr, npc, rw, mw, br, aop, fst, fw, flt} = 10'b0;
        {sa, sb, rs, wsel} = 8'b0;
        case (st)
            4'd0:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = mr; npc = mr; end
            4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            4'd2:  sb = 2'b01;
            4'd3:  adr = 1'b1;
            4'd4:  begin rw = 1'b1; rs = 2'b01; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  aop = 1'b1;
            4'd7:  begin sb = 2'b01; aop = 1'b1; end
            4'd8:  rw = 1'b1;
            4'd9:  begin br = 1'b1; sb = 2'b01; rs = 2'b10; end
            4'd11: fst = fs;
            4'd12: fw = 1'b1;
            4'd13: begin rw = 1'b1; wsel = ws; end
            4'd15: flt = 1'b1;
            default: ;
        endcase
        return {irw, adr, npc, rw, mw, br, aop, sa, sb, rs, wsel, fst, fw, flt};
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input logic [3:0] st, input logic [1:0] ws, input logic fs);
        q.push_back({st, ctl_of(st, mem_ready, ws, fs)});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        mem_ready = 1'b1;
        reset     = 1'b0;
        step(FE, 2'd0, 1'b0);
        reset     = 1'b1;
    endtask

    // Monitor: one record per cycle while the driver has expectations pending.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            rec_n++;
            compared++;
            if (state_o !== e.st) begin
                mismatched++;
                $display("FAIL state rec%0d: got %0d, expected %0d", rec_n, state_o, e.st);
            end
            compared++;
            if (dut_ctl !== e.ctl) begin
                mismatched++;
                $display("FAIL ctl rec%0d (state %0d): got %b, expected %b",
                         rec_n, e.st, dut_ctl, e.ctl);
            end
        end
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; Op = 2'b00; Funct = 6'b000000;
        wide_flag = 1'b0; fpu_done = 1'b0;
        @(posedge clk);
        #1;
        step(FE, 2'd0, 1'b0);
        reset = 1'b1;

        // Register data-processing: 0,1,6,8
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0); step(ER, 2'd0, 1'b0); step(AW, 2'd0, 1'b0);

        // Wide immediate data-processing: 7, then 13 x4 with WideSel 0..3
        Funct = 6'b100000; wide_flag = 1'b1;
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0); step(EI, 2'd0, 1'b0);
        for (int b = 0; b < 4; b++) step(WW, 2'(b), 1'b0);

        // Load with three wait cycles in MEMRD
        Op = 2'b01; Funct = 6'b000001; wide_flag = 1'b0;
        step(FE, 2'd0, 1'b0);
        mem_ready = 1'b0;
        step(DE, 2'd0, 1'b0); step(MA, 2'd0, 1'b0);
        repeat (3) step(MR, 2'd0, 1'b0);
        mem_ready = 1'b1;
        step(MR, 2'd0, 1'b0); step(MB, 2'd0, 1'b0);

        // Store timeout: 16 MemW cycles, then sticky FAULT until reset
        Funct = 6'b000000;
        step(FE, 2'd0, 1'b0);
        mem_ready = 1'b0;
        step(DE, 2'd0, 1'b0); step(MA, 2'd0, 1'b0);
        repeat (16) step(MW, 2'd0, 1'b0);
        repeat (3) step(FL, 2'd0, 1'b0);
        mem_ready = 1'b1;
        step(FL, 2'd0, 1'b0);
        reset_cycle();

        // Store where mem_ready arrives on the limit cycle: no fault
        step(FE, 2'd0, 1'b0);
        mem_ready = 1'b0;
        step(DE, 2'd0, 1'b0); step(MA, 2'd0, 1'b0);
        repeat (15) step(MW, 2'd0, 1'b0);
        mem_ready = 1'b1;
        step(MW, 2'd0, 1'b0);

        // Branch
        Op = 2'b10;
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0); step(BR, 2'd0, 1'b0);

        // FPU instruction
        Op = 2'b11;
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0);
`ifdef MAIN_FSM_FPU_EN
        step(EF, 2'd0, 1'b1);
        repeat (4) step(EF, 2'd0, 1'b0);
        fpu_done = 1'b1;
        step(EF, 2'd0, 1'b0);
        fpu_done = 1'b0;
        step(FW, 2'd0, 1'b0);
`else
        fpu_done = 1'b1;
        step(FL, 2'd0, 1'b0); step(FL, 2'd0, 1'b0);
        fpu_done = 1'b0;
        reset_cycle();
`endif

        // Reset asserted during WIDEWB beat 1
        Op = 2'b00; Funct = 6'b000000; wide_flag = 1'b1;
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0); step(ER, 2'd0, 1'b0); step(WW, 2'd0, 1'b0);
        #2;
        reset_cycle();

        // Wide write-back again: beat counter starts from 0
        step(FE, 2'd0, 1'b0); step(DE, 2'd0, 1'b0); step(ER, 2'd0, 1'b0);
        for (int b = 0; b < 4; b++) step(WW, 2'(b), 1'b0);
        wide_flag = 1'b0;
        step(FE, 2'd0, 1'b0);

        repeat (2) @(posedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending records, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/main_fsm_gen.md
# main_fsm_gen

Parametrised multicycle control FSM for the ARM datapath, successor to the fixed-latency main controller. It adds:
- memory wait states via a `mem_ready` handshake;
- a multi-beat wide-result write-back (`WB_WORDS` register writes);
- an FPU start/done handshake with timeout;
- a sticky fault state.

It sits between the decoder (`Op`/`Funct` from the instruction register) and the datapath/memory/FPU control inputs.

## Interface
- `WB_WORDS`, default 2: register write-back beats for wide (`wide_flag`) results; must be ≥2.
- `MEM_WAIT_MAX`, default 15: maximum cycles a memory state waits for `mem_ready` before faulting.
- `FPU_TIMEOUT`, default 31: maximum cycles `EXECUTEF` waits for `fpu_done` before faulting.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Op` input 2: instruction class. 00 = data-processing, 01 = memory, 10 = branch, 11 = FPU.
- `Funct` input 6: `Funct[5]` selects immediate; `Funct[0]` selects load (1) or store (0).
- `wide_flag` input 1: data-processing result is `WB_WORDS` words wide; sampled in `EXECUTER`/`EXECUTEI`.
- `mem_ready` input 1: memory completes the current access this cycle.
- `fpu_done` input 1: FPU result is valid this cycle.
- Datapath control outputs, widths as in the existing datapath:
  - `IRWrite`, `AdrSrc`, `NextPC`, `RegW`, `MemW`, `Branch`, `ALUOp`: 1 bit each.
  - `ALUSrcA`, `ALUSrcB`, `ResultSrc`: 2 bits each.
- `WideSel` output `max(1,$clog2(WB_WORDS))`: current write-back beat index.
- `FpuStart` output 1: one-cycle FPU launch pulse.
- `FpuW` output 1: FPU result register write.
- `Fault` output 1: sticky; high while in `FAULT`.
- `state_o` output 4: current state encoding, for debug.

## Operation
- State encodings: `FETCH`=0, `DECODE`=1, `MEMADR`=2, `MEMRD`=3, `MEMWB`=4, `MEMWR`=5, `EXECUTER`=6, `EXECUTEI`=7, `ALUWB`=8, `BRANCH`=9, `EXECUTEF`=11, `FPUWB`=12, `WIDEWB`=13, `FAULT`=15.
- Every output not listed for a state is 0.
- Transitions and per-state outputs:
  - `FETCH`: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10. `IRWrite` = `NextPC` = `mem_ready`. Stays until `mem_ready`, then goes to `DECODE`.
  - `DECODE`: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10. Next state by `Op`:
    - 00 with `Funct[5]`=0 → `EXECUTER`; with `Funct[5]`=1 → `EXECUTEI`.
    - 01 → `MEMADR`.
    - 10 → `BRANCH`.
    - 11 → `EXECUTEF`.
  - `EXECUTER`: `ALUOp`=1.
  - `EXECUTEI`: `ALUSrcB`=01, `ALUOp`=1.
  - From `EXECUTER`/`EXECUTEI`: → `WIDEWB` if `wide_flag`, else → `ALUWB`.
  - `ALUWB`: `RegW`=1, then → `FETCH`.
  - `WIDEWB`: `RegW`=1 every beat, `WideSel` = beat counter starting at 0. → `FETCH` after the beat with `WideSel`=`WB_WORDS`-1.
  - `MEMADR`: `ALUSrcB`=01. → `MEMRD` if `Funct[0]`, else → `MEMWR`.
  - `MEMRD`: `AdrSrc`=1. Waits for `mem_ready`, then → `MEMWB`.
  - `MEMWR`: `AdrSrc`=1, `MemW`=1 held until `mem_ready`, then → `FETCH`.
  - `MEMWB`: `RegW`=1, `ResultSrc`=01, then → `FETCH`.
  - `BRANCH`: `Branch`=1, `ALUSrcB`=01, `ResultSrc`=10, then → `FETCH`.
  - `EXECUTEF`: `FpuStart`=1 only on the first cycle in the state. Waits for `fpu_done`, then → `FPUWB`.
  - `FPUWB`: `FpuW`=1, then → `FETCH`.
  - `FAULT`: `Fault`=1, all other outputs 0. Terminal until `reset`.
- Wait counter (shared): cleared on entry to `FETCH`, `MEMRD`, `MEMWR` and `EXECUTEF`; increments each cycle the awaited input is low.
  - Memory states go to `FAULT` when the counter equals `MEM_WAIT_MAX` and `mem_ready`=0.
  - `EXECUTEF` goes to `FAULT` when the counter equals `FPU_TIMEOUT` and `fpu_done`=0.
  - The awaited input arriving on the limit cycle wins: normal transition, no fault.
- `mem_ready`/`fpu_done` are ignored outside their wait states.
- Reset mid-operation (including mid-`WIDEWB` or during `FPU` wait) abandons the instruction with no further writes.

## Timing
- Reset (`reset`=0) forces, asynchronously:
  - state = `FETCH`, wait counter = 0, beat counter = 0;
  - `Fault`=0, `FpuStart`=0, `FpuW`=0, `RegW`=0, `MemW`=0;
  - `FETCH` decode values on the datapath controls (`ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10, `IRWrite`/`NextPC` following `mem_ready`).
- State register updates on the rising edge of `clk`. Outputs decode combinationally from state, plus `mem_ready` in `FETCH`.
- Latency in cycles with `mem_ready` tied 1:
  - data-processing: 4;
  - wide data-processing: 3+`WB_WORDS`;
  - load: 5;
  - store: 4;
  - branch: 3;
  - FPU: 4 + (cycles until `fpu_done`).
- Each memory state adds one cycle per low `mem_ready` cycle.

## Configuration
- `MAIN_FSM_FPU_EN` defined: FPU path as above.
- Not defined:
  - `Op`=11 in `DECODE` → `FAULT`;
  - `EXECUTEF`/`FPUWB` logic removed;
  - `FpuStart` and `FpuW` tied 0;
  - `fpu_done` unused.

## Test plan
- `reset` low then high, `mem_ready`=1, `Op`=00, `Funct`=6'b000000, `wide_flag`=0 → states 0,1,6,8,0. `RegW`=1 only in cycle 4; `IRWrite`=1 in cycle 1.
- `WB_WORDS`=4, `Op`=00, `Funct[5]`=1, `wide_flag`=1 → 7 then 13 for 4 cycles. `WideSel` 0,1,2,3 with `RegW`=1 each beat, then `FETCH`.
- Load (`Op`=01, `Funct[0]`=1) with `mem_ready` low for 3 cycles in `MEMRD` → `AdrSrc`=1 held 4 cycles. `MEMWB` gives `RegW`=1, `ResultSrc`=01.
- Store with `mem_ready` stuck 0, `MEM_WAIT_MAX`=15 → `MemW` high 16 cycles, then `FAULT` (`state_o`=15, `Fault`=1) until `reset`. Repeat with `mem_ready` rising on the 16th cycle → no fault.
- `MAIN_FSM_FPU_EN` defined, `Op`=11, `fpu_done` after 5 cycles → `FpuStart` a single pulse, then `FpuW`=1 for one cycle. Undefined → `FAULT` after `DECODE`.
- Assert `reset` in the middle of `WIDEWB` beat 1 → immediate `FETCH`, `RegW`=0, counters 0.
